// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver feeding a small scan-code FIFO.
// The FIFO head is presented to the core on keyboard_in; keyboard_ack pops it.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clock,
    input  logic        ps2_data,
    input  logic        keyboard_ack,
    output logic [31:0] keyboard_in,
    output logic        fifo_full,
    output logic        frame_err,
    output logic        overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             dat_s1_q, dat_s2_q;
    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic fe;
    logic push_req;
    logic push;
    logic pop;
    logic full;

    assign fe = clk_prev_q & ~clk_s2_q;

    // Frame deserialiser and inactivity watchdog.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fe && !dat_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (fe) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push at full still lands.
    always_comb begin
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = keyboard_ack && (count_q != '0);
        push       = push_req && (!full || pop);
        overflow_d = push_req && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            clk_s1_q    <= ps2_clock;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q gates visibility, so stale entries are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign keyboard_in = (count_q != '0) ? {23'b0, 1'b1, mem_q[rd_ptr_q]} : 32'h0;
    assign fifo_full   = full;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: a queue model of the scan-code buffer checked every
// cycle, plus literal expectations for each directed scenario.
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        ps2_clock;
    logic        ps2_data;
    logic        keyboard_ack;
    logic [31:0] keyboard_in;
    logic        fifo_full;
    logic        frame_err;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int err_seen  = 0;
    int ovf_seen  = 0;
    int exp_err   = 0;
    int exp_ovf   = 0;
    int last_fall = 0;
    bit busy      = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    ps2_keyboard_rx #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ps2_clock    (ps2_clock),
        .ps2_data     (ps2_data),
        .keyboard_ack (keyboard_ack),
        .keyboard_in  (keyboard_in),
        .fifo_full    (fifo_full),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_out();
        if (exp_q.size() != 0) return {23'b0, 1'b1, exp_q[0]};
        return 32'h0;
    endfunction

    // Model of the buffer: a frame is good when the stop bit is 1 and data+parity has odd weight.
    task automatic apply_frame(input logic [7:0] d, input logic good, input logic popped);
        if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
        if (good) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf++;
        end else begin
            exp_err++;
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (!busy) begin
                check("keyboard_in_vs_model", keyboard_in, model_out());
                check("fifo_full_vs_model", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic ack_at_push);
        logic par;
        logic good;
        par = ~(^d) ^ flip_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b0;
        busy = 1'b1;
        good = (^{d, par}) == 1'b1;
        if (ack_at_push) begin
            repeat (2) @(negedge clock);
            keyboard_ack = 1'b1;
            apply_frame(d, good, 1'b1);
            @(negedge clock);
            keyboard_ack = 1'b0;
            repeat (3) @(negedge clock);
        end else begin
            repeat (5) @(negedge clock);
            apply_frame(d, good, 1'b0);
        end
        busy = 1'b0;
        repeat (HALF - 6) @(negedge clock);
        ps2_clock = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        keyboard_ack = 1'b1;
        @(posedge clock);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        #1 keyboard_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int o0;
        int dt;
        bit found;

        reset        = 1'b0;
        ps2_clock    = 1'b1;
        ps2_data     = 1'b1;
        keyboard_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_keyboard_in", keyboard_in, 32'h0);
        check("reset_fifo_full", 32'(fifo_full), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (5) @(negedge clock);

        // Single good frame 0x1C, then one acknowledge.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("single_1c", keyboard_in, 32'h0000_011C);
        ack_pulse();
        @(negedge clock);
        check("single_after_ack", keyboard_in, 32'h0);

        // Parity error, then a good 0xF0.
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 1'b0);
        check("parity_err_pulses", 32'(err_seen - e0), 32'd1);
        check("parity_err_no_push", keyboard_in, 32'h0);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("after_err_f0", keyboard_in, 32'h0000_01F0);
        ack_pulse();

        // Overflow on the ninth frame with no acknowledges.
        o0 = ovf_seen;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_full_after_8", 32'(fifo_full), 32'h1);
        check("ovf_none_before_9", 32'(ovf_seen - o0), 32'd0);
        send_frame(8'h09, 1'b0, 1'b0);
        check("ovf_pulse_on_9", 32'(ovf_seen - o0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            check("ovf_readout", keyboard_in, 32'h100 + 32'(i));
            ack_pulse();
        end
        @(negedge clock);
        check("ovf_drained", keyboard_in, 32'h0);

        // Push and pop in the same cycle while full.
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        o0 = ovf_seen;
        send_frame(8'h09, 1'b0, 1'b1);
        check("pp_no_overflow", 32'(ovf_seen - o0), 32'd0);
        check("pp_head_02", keyboard_in, 32'h0000_0102);
        check("pp_still_full", 32'(fifo_full), 32'h1);
        for (int i = 2; i <= 9; i++) begin
            @(negedge clock);
            check("pp_readout", keyboard_in, 32'h100 + 32'(i));
            ack_pulse();
        end
        @(negedge clock);
        check("pp_drained", keyboard_in, 32'h0);

        // Timeout after start plus four data bits of 0x1C.
        e0 = err_seen;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        found = 1'b0;
        dt    = 0;
        for (int k = 0; k < TMO + 50 && !found; k++) begin
            @(negedge clock);
            if (frame_err) begin
                found = 1'b1;
                dt    = cyc - last_fall;
            end
        end
        check("timeout_seen", 32'(found), 32'h1);
        check("timeout_delay_in_window", 32'(dt >= TMO && dt <= TMO + 6), 32'h1);
        exp_err++;
        repeat (5) @(negedge clock);
        check("timeout_single_pulse", 32'(err_seen - e0), 32'd1);
        check("timeout_no_push", keyboard_in, 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("after_timeout_1c", keyboard_in, 32'h0000_011C);
        ack_pulse();

        // Reset mid-frame with two entries queued; frame 0xE1 is cut after five data bits.
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        repeat (3) @(negedge clock);
        #3 reset = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_keyboard_in", keyboard_in, 32'h0);
        check("rst_async_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_async_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        e0 = err_seen;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (10) @(negedge clock);
        check("rst_tail_not_pushed", keyboard_in, 32'h0);
        check("rst_tail_no_err", 32'(err_seen - e0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("rst_next_frame_5a", keyboard_in, 32'h0000_015A);
        ack_pulse();
        repeat (5) @(negedge clock);

        check("total_frame_err_pulses", 32'(err_seen), 32'(exp_err));
        check("total_overflow_pulses", 32'(ovf_seen), 32'(exp_ovf));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 host-side receiver and scan-code buffer that sits directly upstream of the processor core.
- Deserialises 11-bit PS/2 device-to-host frames and checks start, odd parity and stop bits.
- Queues good scan codes in a small FIFO.
- Presents the FIFO head on the core's keyboard_in bus; the core's keyboard_ack pops one entry per acknowledged cycle.

Parameters:
- FIFO_DEPTH, 8, number of buffered scan codes; power of 2, at least 2.
- TIMEOUT_CYCLES, 50000, system clocks without a ps2_clock falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clock  input  1  raw PS/2 clock from the device, asynchronous to clock.
- ps2_data  input  1  raw PS/2 data from the device, asynchronous to clock.
- keyboard_ack  input  1  core pop request; pops the head at the rising edge.
- keyboard_in  output  32  {23'b0, valid, scan_code[7:0]}; all zero when the FIFO is empty.
- fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
- overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; pointers and count return to 0.
  - FSM returns to IDLE; shift register, bit counter and timeout counter are cleared.
  - Synchroniser flops load 1.
  - Output reset values: keyboard_in=0, fifo_full=0, frame_err=0, overflow=0.
  - A frame in progress when reset asserts is discarded. After release, reception restarts at the next start bit.
- Input conditioning:
  - ps2_clock and ps2_data each pass through a 2-flop synchroniser.
  - A falling edge (fe) is the synchronised clock equal to 0 with its previous value equal to 1.
  - Data is sampled only on fe cycles.
- FSM:
  - IDLE: fe with data=0 -> DATA, bitcnt=0. fe with data=1 is ignored and the FSM stays in IDLE.
  - DATA: each fe shifts data in LSB-first and increments bitcnt. On the 8th bit -> PARITY.
  - PARITY: fe latches the parity bit -> STOP.
  - STOP: fe checks the frame, then -> IDLE.
    - Stop bit is 1 and the XOR of the 8 data bits plus parity is 1: push the byte.
    - Otherwise: frame_err pulses the next cycle and nothing is pushed.
  - Timeout:
    - In any state other than IDLE, the counter increments every cycle and clears on fe.
    - When it reaches TIMEOUT_CYCLES-1: -> IDLE and frame_err pulses. The partial byte is discarded.
- FIFO:
  - Storage is registered; keyboard_in is driven combinationally from the head entry and count.
  - Push latency: the byte is visible on keyboard_in (valid=1) in the first cycle after the push edge.
  - Pop: keyboard_ack=1 with count>0 advances the head at the rising edge. keyboard_ack with an empty FIFO has no effect.
  - Push with the FIFO full and no pop in the same cycle: the byte is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle:
    - Both take effect and count is unchanged.
    - At full this succeeds with no overflow.
    - At empty, the pushed byte becomes the head.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - count has one extra bit; fifo_full = (count == FIFO_DEPTH).
- The core must assert keyboard_ack for exactly one cycle per read; a level held high pops every cycle.

Test Plan:
- Single frame, scan code 0x1C: bit sequence start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1, ps2_clock period 80 us.
  - Required: keyboard_in = 0x0000011C one cycle after the stop edge.
  - Then a one-cycle keyboard_ack -> keyboard_in = 0.
- Parity error: 0x1C sent with parity bit 1.
  - Required: frame_err pulses once, keyboard_in stays 0, and the next good frame (0xF0) reads 0x000001F0.
- Overflow: 9 good frames 0x01..0x09 with no ack.
  - Required: fifo_full=1 after the 8th frame; overflow pulses on the 9th.
  - Eight acks then return 0x101..0x108 in order, followed by 0.
- Simultaneous push/pop at full: FIFO full, keyboard_ack held for the single cycle of the 9th push.
  - Required: no overflow, count stays 8, head advances to 0x02, and 0x09 reads out last.
- Timeout: stop toggling ps2_clock after 4 data bits.
  - Required: frame_err pulses TIMEOUT_CYCLES cycles after the last edge, the FSM is back in IDLE, and a following 0x1C frame is received correctly.
- Reset mid-frame: drive reset=0 after 5 data bits with 2 entries queued.
  - Required: keyboard_in=0 and fifo_full=0 immediately, without waiting for a clock edge.
  - After release, the remaining bits of the interrupted frame (the tail of that frame) are not pushed, and the next full frame is received.
